apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB responder (completer) for the AHB-APB bridge. It is the other end of the Pselx/Penable/Pwrite/Paddr/PWdata/PRdata interface.
- Implements a small memory-mapped register file with a read-only ID register, optional wait states and error signalling.
- One instance attaches to one bit of the bridge's 3-bit Pselx. It is used both as a bridge verification target and as a real peripheral register bank.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; power of 2, range 2..256. Index 0 is the read-only ID register.
- WAIT_STATES, 0, wait cycles inserted before Pready; range 0..15. A value of 0 matches the bridge's fixed 2-cycle transfer.
- BASE_ADDR, 32'h8000_0000, decode base; only bits [31:12] are compared.
- ID_VALUE, 32'hA5B1_0001, value returned by register 0.

Ports:
- Hclk     input   1   clock; all state updates on the rising edge.
- Hresetn  input   1   reset Hresetn, asynchronous, active-high.
- Psel     input   1   slave select (one bit of bridge Pselx).
- Penable  input   1   APB access phase.
- Pwrite   input   1   1 = write, 0 = read.
- Paddr    input   32  byte address.
- PWdata   input   32  write data.
- PRdata   output  32  read data; registered.
- Pready   output  1   transfer complete; registered.
- Pslverr  output  1   transfer error; valid only while Pready=1; registered.

Behaviour:
- Reset (Hresetn=1, asynchronous):
  - State goes to ST_IDLE.
  - PRdata=0, Pready=0, Pslverr=0, wait counter=0.
  - Registers 1..NUM_REGS-1 are cleared to 0.
  - A reset asserted mid-transfer aborts it; no write is committed.
- Decode, evaluated on the setup sample:
  - hit = (Paddr[31:12]==BASE_ADDR[31:12]).
  - idx = Paddr[11:2].
  - err = ~hit | (idx>=NUM_REGS) | (Paddr[1:0]!=0) | (Pwrite & idx==0).
  - Latch idx, Pwrite and err.
- States: ST_IDLE, ST_WAIT, ST_ACCESS.
- ST_IDLE:
  - On an edge with Psel=1 and Penable=0 (setup phase), latch the decode.
  - For a read with err=0, load PRdata = reg[idx] (ID_VALUE if idx==0). Otherwise load PRdata=0.
  - If WAIT_STATES==0, go to ST_ACCESS. Otherwise load cnt=WAIT_STATES and go to ST_WAIT.
  - Psel=1 with Penable=1 while in IDLE is a protocol violation: ignore it and stay in ST_IDLE.
- ST_WAIT (Pready=0):
  - On each edge, if Psel=0, abort to ST_IDLE.
  - Otherwise cnt<=cnt-1. When cnt==1 at the edge, go to ST_ACCESS.
- ST_ACCESS:
  - Pready=1 and Pslverr=latched err.
  - At the next edge, if Psel=1 and Penable=1: commit the write when latched Pwrite=1 and err=0 (reg[idx]<=PWdata sampled at this edge), then go to ST_IDLE.
  - If Psel=0 or Penable=0 at that edge: abort with no write and go to ST_IDLE.
- Exit from ST_ACCESS: Pready, Pslverr and PRdata all clear to 0 in the same edge.
- Latency: a transfer occupies 2+WAIT_STATES cycles (setup, WAIT_STATES wait cycles, 1 ready cycle).
- Back-to-back: a new setup phase in the cycle right after ST_ACCESS is accepted with no idle cycle (supports the bridge's RENABLE->READ and WENABLEP->WRITEP paths).
- Errored writes never modify any register. Errored reads return PRdata=0.
- A read of a register in the same transfer sequence as a preceding write returns the new value; the write committed at the earlier edge.
- Pready and Pslverr are never asserted outside ST_ACCESS.

Test Plan:
- Write 0x8000_0004 <= 0xDEADBEEF, then read 0x8000_0004 -> on the read's second cycle Pready=1, Pslverr=0, PRdata=0xDEADBEEF; each transfer takes 2 cycles.
- Read 0x8000_0000 -> PRdata=0xA5B1_0001. Write 0x1234_5678 to 0x8000_0000 -> Pslverr=1 with Pready; a re-read still returns 0xA5B1_0001.
- NUM_REGS=8: read 0x8000_0020 -> Pslverr=1, PRdata=0. Read 0x9000_0004 -> Pslverr=1. Read 0x8000_0006 -> Pslverr=1, no register changed.
- WAIT_STATES=2: write to 0x8000_0008 -> Pready=0 for access cycles 1-2 and =1 on cycle 3; total 4 cycles; register updated only at the end of cycle 4.
- Psel dropped during ST_WAIT, and separately Hresetn asserted during ST_ACCESS of a write 0x8000_000C <= 0x55 -> state returns to ST_IDLE, Pready=0, register 3 reads 0 afterwards.
- Back-to-back bridge stream: write reg1=0x11, write reg2=0x22, read reg1, read reg2 with no idle cycles -> reads return 0x11 and 0x22, Pslverr=0 throughout.

Source files
------------

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile
//  Purpose  : APB completer holding a small memory-mapped register file.
//             Register 0 is a read-only ID register; registers 1..NUM_REGS-1
//             are read/write. Optional wait states are inserted before
//             Pready, and decode/permission errors are flagged on Pslverr.
//  Ports    : Hclk     - clock, rising edge
//             Hresetn  - asynchronous reset, active-high
//             Psel     - slave select (one bit of the bridge Pselx)
//             Penable  - APB access phase
//             Pwrite   - 1 = write, 0 = read
//             Paddr    - byte address [31:0]
//             PWdata   - write data [31:0]
//             PRdata   - registered read data [31:0]
//             Pready   - registered transfer-complete
//             Pslverr  - registered transfer error (valid with Pready)
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hA5B1_0001
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] PWdata,
    output logic [31:0] PRdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int         C_IDX_W  = $clog2(NUM_REGS);
    localparam logic [3:0] C_WAIT   = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q,  state_d;
    logic [3:0]         cnt_q,    cnt_d;
    logic [C_IDX_W-1:0] idx_q,    idx_d;
    logic               write_q,  write_d;
    logic               err_q,    err_d;
    logic [31:0]        rdata_q,  rdata_d;
    logic               ready_q,  ready_d;
    logic               slverr_q, slverr_d;

    // ------------------------------------------------------------------
    // Address decode (only meaningful on the setup sample)
    // ------------------------------------------------------------------
    logic [9:0]         w_idx_full;
    logic [C_IDX_W-1:0] w_idx;
    logic               w_hit;
    logic               w_oor;
    logic               w_err;
    logic               w_setup;
    logic               w_xfer;
    logic               w_wr_en;

    assign w_idx_full = Paddr[11:2];
    assign w_idx      = w_idx_full[C_IDX_W-1:0];
    assign w_hit      = (Paddr[31:12] == BASE_ADDR[31:12]);
    // Compare at full width so indices beyond the array never alias back in.
    assign w_oor      = ({22'd0, w_idx_full} >= 32'(NUM_REGS));
    assign w_err      = ~w_hit | w_oor | (Paddr[1:0] != 2'b00)
                      | (Pwrite & (w_idx_full == 10'd0));
    assign w_setup    = Psel & ~Penable;
    assign w_xfer     = Psel & Penable;

    // ------------------------------------------------------------------
    // Register storage and read vector (entry 0 is the constant ID)
    // ------------------------------------------------------------------
    logic [31:0] w_rd_vec [NUM_REGS];

    assign w_rd_vec[0] = ID_VALUE;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
            logic [31:0] reg_q;
            logic [31:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (w_wr_en && (idx_q == C_IDX_W'(i))) begin
                    reg_d = PWdata;
                end
            end

            always_ff @(posedge Hclk or posedge Hresetn) begin
                if (Hresetn) begin
                    reg_q <= 32'd0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign w_rd_vec[i] = reg_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transfer sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        w_wr_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Psel with Penable already high here is a protocol
                // violation and is simply ignored.
                if (w_setup) begin
                    idx_d   = w_idx;
                    write_d = Pwrite;
                    err_d   = w_err;
                    rdata_d = (!Pwrite && !w_err) ? w_rd_vec[w_idx] : 32'd0;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        cnt_d   = C_WAIT;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (!Psel) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                // Always leave after one ready cycle; the write only lands
                // if the master completed the access phase properly.
                state_d = ST_IDLE;
                rdata_d = 32'd0;
                w_wr_en = w_xfer & write_q & ~err_q;
            end

            default: begin
                state_d = ST_IDLE;
                rdata_d = 32'd0;
            end
        endcase

        // Outputs are registered, so derive them from the next state.
        ready_d  = (state_d == ST_ACCESS);
        slverr_d = (state_d == ST_ACCESS) & err_d;
    end

    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
        end
    end

    assign PRdata  = rdata_q;
    assign Pready  = ready_q;
    assign Pslverr = slverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_slave_regfile
//  Purpose  : Self-checking bench for apb_slave_regfile. Two instances share
//             the bus (0 wait states and 2 wait states), each with its own
//             select. A reference register model predicts read data,
//             error flags and wait-state counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

    localparam logic [31:0] C_ID   = 32'hA5B1_0001;
    localparam int          C_NREG = 8;

    logic        clk;
    logic        rst;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int n_cmp = 0;
    int n_err = 0;
    int ws [2] = '{0, 2};
    logic [31:0] model [2][C_NREG];

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0)) u_dut0 (
        .Hclk(clk), .Hresetn(rst), .Psel(psel0), .Penable(penable),
        .Pwrite(pwrite), .Paddr(paddr), .PWdata(pwdata),
        .PRdata(prdata0), .Pready(pready0), .Pslverr(pslverr0)
    );

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(2)) u_dut1 (
        .Hclk(clk), .Hresetn(rst), .Psel(psel1), .Penable(penable),
        .Pwrite(pwrite), .Paddr(paddr), .PWdata(pwdata),
        .PRdata(prdata1), .Pready(pready1), .Pslverr(pslverr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_rdy(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? pslverr0 : pslverr1;
    endfunction
    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? prdata0 : prdata1;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < C_NREG; r++)
                model[d][r] = 32'd0;
    endtask

    // One complete transfer. Starts on the negedge after the previous
    // transfer's final edge, so consecutive calls are back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int          waits;
        int          idx;
        bit          exp_err;
        logic [31:0] exp_rd;
        @(negedge clk);
        chk("rdy_before_setup", 32'(get_rdy(d)), 32'd0);
        psel0   = (d == 0);
        psel1   = (d == 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        idx     = int'(addr[11:2]);
        exp_err = (addr[31:12] != 20'h80000) || (idx >= C_NREG) ||
                  (addr[1:0] != 2'b00) || (wr && idx == 0);
        if (wr || exp_err)  exp_rd = 32'd0;
        else if (idx == 0)  exp_rd = C_ID;
        else                exp_rd = model[d][idx];
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        waits   = 0;
        while (!get_rdy(d) && waits < 20) begin
            chk("slverr_in_wait", 32'(get_err(d)), 32'd0);
            @(posedge clk);
            @(negedge clk);
            waits++;
        end
        chk("wait_cycles", 32'(waits), 32'(ws[d]));
        chk("slverr", 32'(get_err(d)), 32'(exp_err));
        chk("prdata", get_rd(d), exp_rd);
        chk("other_rdy", 32'(get_rdy(1 - d)), 32'd0);
        @(posedge clk);
        if (wr && !exp_err) model[d][idx] = wdata;
    endtask

    task automatic idle();
        @(negedge clk);
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        @(posedge clk);
    endtask

    logic [31:0] r_addr;
    int          r_dev;
    int          r_idx;

    initial begin
        rst = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata", prdata0, 32'd0);
        chk("rst_pready", 32'(pready0), 32'd0);
        chk("rst_pslverr", 32'(pslverr1), 32'd0);
        rst = 1'b0;
        idle();

        // Basic write then read, and the read-only ID register
        xfer(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h8000_0004, 32'd0);
        xfer(0, 1'b0, 32'h8000_0000, 32'd0);
        xfer(0, 1'b1, 32'h8000_0000, 32'h1234_5678);
        xfer(0, 1'b0, 32'h8000_0000, 32'd0);
        idle();

        // Decode errors: out of range, wrong base, misaligned
        xfer(0, 1'b0, 32'h8000_0020, 32'd0);
        xfer(0, 1'b0, 32'h9000_0004, 32'd0);
        xfer(0, 1'b0, 32'h8000_0006, 32'd0);
        xfer(0, 1'b1, 32'h8000_0006, 32'hFFFF_FFFF);
        xfer(0, 1'b0, 32'h8000_0004, 32'd0);

        // Wait-state instance
        xfer(1, 1'b1, 32'h8000_0008, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'h8000_0008, 32'd0);
        idle();

        // Psel dropped while waiting: nothing committed
        @(negedge clk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h8000_000C; pwdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        chk("wait_abort_rdy0", 32'(pready1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        psel1 = 1'b0; penable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wait_abort_idle_rdy", 32'(pready1), 32'd0);
        xfer(1, 1'b0, 32'h8000_000C, 32'd0);

        // Reset asserted in the ready cycle of a write: nothing committed
        @(negedge clk);
        psel0 = 1'b1; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h8000_000C; pwdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        chk("acc_rdy", 32'(pready0), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_abort_rdy", 32'(pready0), 32'd0);
        chk("rst_abort_err", 32'(pslverr0), 32'd0);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; psel0 = 1'b0; penable = 1'b0;
        @(posedge clk);
        xfer(0, 1'b0, 32'h8000_000C, 32'd0);
        xfer(0, 1'b0, 32'h8000_0004, 32'd0);
        idle();

        // Back-to-back bridge stream on both instances
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 32'h8000_0004, 32'h11);
            xfer(d, 1'b1, 32'h8000_0008, 32'h22);
            xfer(d, 1'b0, 32'h8000_0004, 32'd0);
            xfer(d, 1'b0, 32'h8000_0008, 32'd0);
            idle();
        end

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            r_dev = int'($urandom_range(0, 1));
            r_idx = int'($urandom_range(0, C_NREG - 1));
            case ($urandom_range(0, 9))
                8: r_addr = 32'h8000_0000 | (32'($urandom_range(8, 1023)) << 2);
                9: begin
                    r_addr = $urandom;
                    r_addr[31:28] = 4'h9;
                end
                7: r_addr = 32'h8000_0000 | (32'(r_idx) << 2) | 32'($urandom_range(1, 3));
                default: r_addr = 32'h8000_0000 | (32'(r_idx) << 2);
            endcase
            xfer(r_dev, 1'($urandom_range(0, 1)), r_addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // Final sweep of every register on both instances
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < C_NREG; r++)
                xfer(d, 1'b0, 32'h8000_0000 | (32'(r) << 2), 32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
